// File: rtl/tm1638_types_pkg.sv
// Shared TM1638 types: command builders, display enums and the frame sequencer state.
// A command word is {1'b0, has_data, data[7:0], command_byte[7:0]}.
package tm1638_types;

   typedef logic [17:0] command_t;
   typedef logic [7:0]  data_t;
   typedef logic [2:0]  brightness_t;

   typedef enum logic { SHOW_OFF = 1'b0, SHOW_ON = 1'b1 } show_t;
   typedef enum logic { ADDR_MODE_AUTO = 1'b0, ADDR_MODE_FIXED = 1'b1 } addr_mode_t;
   typedef enum logic { DATA_MODE_NORMAL = 1'b0, DATA_MODE_TEST = 1'b1 } data_mode_t;

   // Display register index: grid in the upper bits, segment half in bit 0.
   typedef struct packed {
      logic [2:0] grid;
      logic       segment;
   } register_t;

   typedef enum logic [2:0] {
      SEQ_IDLE,
      SEQ_DATA_CMD,
      SEQ_ADDR,
      SEQ_CTRL,
      SEQ_DONE
   } tm1638_seq_state_t;

   localparam int unsigned NUM_REGS = 16;
   localparam logic [7:0]  CMD_DATA = 8'h40;
   localparam logic [7:0]  CMD_CTRL = 8'h80;
   localparam logic [7:0]  CMD_ADDR = 8'hC0;

   function automatic command_t make_write_data_command(input addr_mode_t am, input data_mode_t dm);
      return {10'd0, CMD_DATA | {4'b0000, dm, am, 2'b00}};
   endfunction

   function automatic command_t make_addr_command_and_data(input logic [2:0] grid, input data_t data,
                                                           input logic segment);
      return {1'b0, 1'b1, data, CMD_ADDR | {4'b0000, grid, segment}};
   endfunction

   function automatic command_t make_control_command(input show_t show, input brightness_t brightness);
      return {10'd0, CMD_CTRL | {4'b0000, show, brightness}};
   endfunction

endpackage

// File: rtl/tm1638_refresh_timer.sv
// Idle-time refresh counter: held at zero by clear, ticks on its last count.
module tm1638_refresh_timer #(
   parameter int unsigned REFRESH_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CNT_W = $clog2((REFRESH_CYCLES > 1) ? REFRESH_CYCLES : 2);
   localparam logic [CNT_W-1:0] LAST = CNT_W'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q + CNT_W'(1);
      if (clear || (count_q == LAST)) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // A zero period disables auto-refresh entirely.
   assign tick = (REFRESH_CYCLES != 0) && !clear && (count_q == LAST);

endmodule

// File: rtl/tm1638_frame_sequencer.sv
// Emits one TM1638 frame (data command, 16 address/data writes, control) per trigger
// over a valid/ready command stream, with update coalescing and periodic refresh.
module tm1638_frame_sequencer
   import tm1638_types::*;
#(
   parameter int unsigned REFRESH_CYCLES = 1_000_000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               update,
   input  data_t [15:0]       regs,
   input  brightness_t        brightness,
   input  show_t              show,
   output command_t           cmd,
   output logic               cmd_valid,
   input  logic               cmd_ready,
   output logic               busy,
   output logic               frame_done
);

   tm1638_seq_state_t state_q, state_d;
   logic [3:0]        idx_q, idx_d;
   logic              pending_q, pending_d;
   data_t [15:0]      regs_q, regs_d;
   brightness_t       bright_q, bright_d;
   show_t             show_q, show_d;
   logic              snap;
   logic              refresh_tick;
   register_t         reg_sel;

   tm1638_refresh_timer #(
      .REFRESH_CYCLES(REFRESH_CYCLES)
   ) u_refresh (
      .clk  (clk),
      .rst_n(rst_n),
      .clear(state_q != SEQ_IDLE),
      .tick (refresh_tick)
   );

   assign reg_sel = register_t'(idx_q);

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      pending_d  = pending_q;
      regs_d     = regs_q;
      bright_d   = bright_q;
      show_d     = show_q;
      snap       = 1'b0;
      cmd        = '0;
      cmd_valid  = 1'b0;
      busy       = 1'b1;
      frame_done = 1'b0;

      case (state_q)
         SEQ_IDLE: begin
            busy = 1'b0;
            if (update || refresh_tick) begin
               state_d = SEQ_DATA_CMD;
               snap    = 1'b1;
            end
         end
         SEQ_DATA_CMD: begin
            cmd_valid = 1'b1;
            cmd       = make_write_data_command(ADDR_MODE_FIXED, DATA_MODE_NORMAL);
            if (cmd_ready) begin
               state_d = SEQ_ADDR;
               idx_d   = '0;
            end
         end
         SEQ_ADDR: begin
            cmd_valid = 1'b1;
            cmd       = make_addr_command_and_data(reg_sel.grid, regs_q[idx_q], reg_sel.segment);
            if (cmd_ready) begin
               if (idx_q == 4'(NUM_REGS - 1)) begin
                  state_d = SEQ_CTRL;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         SEQ_CTRL: begin
            cmd_valid = 1'b1;
            cmd       = make_control_command(show_q, bright_q);
            if (cmd_ready) begin
               state_d = SEQ_DONE;
            end
         end
         SEQ_DONE: begin
            frame_done = 1'b1;
            // Back-to-back restart when an update arrived during the frame.
            if (pending_q || update) begin
               pending_d = 1'b0;
               state_d   = SEQ_DATA_CMD;
               snap      = 1'b1;
            end else begin
               state_d = SEQ_IDLE;
            end
         end
         default: begin
            state_d = SEQ_IDLE;
         end
      endcase

      if (update && (state_q inside {SEQ_DATA_CMD, SEQ_ADDR, SEQ_CTRL})) begin
         pending_d = 1'b1;
      end

      if (snap) begin
         regs_d   = regs;
         bright_d = brightness;
         show_d   = show;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= SEQ_IDLE;
         idx_q     <= '0;
         pending_q <= 1'b0;
         regs_q    <= '0;
         bright_q  <= '0;
         show_q    <= SHOW_OFF;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
         regs_q    <= regs_d;
         bright_q  <= bright_d;
         show_q    <= show_d;
      end
   end

endmodule

// File: tb/tb_tm1638_frame_sequencer.sv
// Directed/randomized bench for tm1638_frame_sequencer against a frame-level reference model.
`timescale 1ns/1ps
module tb_tm1638_frame_sequencer;
   import tm1638_types::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n, update, cmd_ready, update_r;
   data_t [15:0] regs;
   brightness_t  brightness;
   show_t        show;
   command_t     cmd, cmd_r;
   logic         cmd_valid, busy, frame_done;
   logic         cmd_valid_r, busy_r, frame_done_r;

   int total = 0;
   int bad   = 0;

   tm1638_frame_sequencer #(.REFRESH_CYCLES(0)) dut (
      .clk(clk), .rst_n(rst_n), .update(update), .regs(regs), .brightness(brightness),
      .show(show), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .busy(busy), .frame_done(frame_done));

   tm1638_frame_sequencer #(.REFRESH_CYCLES(20)) dut_r (
      .clk(clk), .rst_n(rst_n), .update(update_r), .regs(regs), .brightness(brightness),
      .show(show), .cmd(cmd_r), .cmd_valid(cmd_valid_r), .cmd_ready(1'b1),
      .busy(busy_r), .frame_done(frame_done_r));

   // Observation state updated once per cycle by step().
   int       cyc = 0;
   command_t got_q[$];
   command_t r_got_q[$];
   int       done_cnt = 0, last_xfer_cyc = -10, first_xfer_cyc = 0;
   int       r_done_cnt = 0, r_done_cyc = 0, r_rise_cyc = 0;
   int       busy_low = 0;
   logic     prev_stall = 1'b0, r_prev_valid = 1'b0;
   command_t prev_cmd = '0;
   bit       rand_ready = 1'b0;
   bit       watch_busy = 1'b0;
   command_t exp_w[18];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Reference frame from the command rules: data cmd, 16 address writes, control.
   task automatic model_frame(input data_t [15:0] r, input brightness_t b, input logic s);
      exp_w[0] = 18'h00044;
      for (int k = 0; k < 16; k++) begin
         exp_w[k+1] = command_t'(32'h10000 + 32'(r[k]) * 256 + 32'hC0 + k);
      end
      exp_w[17] = command_t'(32'h80 + 32'(s) * 8 + 32'(b));
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
         check("stall_valid", 32'(cmd_valid), 1);
         check("stall_cmd", 32'(cmd), 32'(prev_cmd));
      end
      if (frame_done) begin
         done_cnt++;
         check("done_timing", cyc, last_xfer_cyc + 1);
      end
      if (watch_busy && !busy) busy_low++;
      if (cmd_valid && cmd_ready) begin
         if (got_q.size() == 0) first_xfer_cyc = cyc;
         got_q.push_back(cmd);
         last_xfer_cyc = cyc;
      end
      prev_stall = cmd_valid && !cmd_ready;
      prev_cmd   = cmd;
      if (cmd_valid_r && !r_prev_valid) r_rise_cyc = cyc;
      r_prev_valid = cmd_valid_r;
      if (cmd_valid_r) r_got_q.push_back(cmd_r);
      if (frame_done_r) begin
         r_done_cnt++;
         r_done_cyc = cyc;
      end
      @(posedge clk);
      #1;
      cmd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic pulse_update();
      update = 1'b1;
      step();
      update = 1'b0;
   endtask

   task automatic wait_words(input string tag, input int n, input int budget);
      int b;
      b = 0;
      while (got_q.size() < n && b < budget) begin
         step();
         b++;
      end
      if (got_q.size() < n) check({tag, "_timeout"}, got_q.size(), n);
   endtask

   task automatic check_frame(input string tag);
      check({tag, "_count"}, 32'(got_q.size() >= 18), 1);
      for (int i = 0; i < 18; i++) begin
         if (got_q.size() == 0) break;
         check($sformatf("%s_w%0d", tag, i), 32'(got_q.pop_front()), 32'(exp_w[i]));
      end
   endtask

   task automatic randomize_inputs();
      for (int i = 0; i < 16; i++) regs[i] = data_t'($urandom);
      brightness = brightness_t'($urandom_range(0, 7));
      show       = show_t'($urandom_range(0, 1));
   endtask

   initial begin
      data_t [15:0] regs_a;
      brightness_t  bright_a;
      show_t        show_a;
      int           d0, d, s, b;

      rst_n = 1'b0; update = 1'b0; update_r = 1'b0; cmd_ready = 1'b1;
      regs = '0; brightness = '0; show = SHOW_OFF;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_valid", 32'(cmd_valid), 0);
      check("rst_cmd", 32'(cmd), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(frame_done), 0);
      check("rst_busy_r", 32'(busy_r), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) step();
      check("idle_no_words", got_q.size(), 0);
      check("idle_busy", 32'(busy), 0);

      // Directed frame with known image
      regs = '0; regs[0] = 8'h3F; regs[5] = 8'h06; brightness = 3'd7; show = SHOW_ON;
      model_frame(regs, brightness, 1'b1);
      check("model_w1", 32'(exp_w[1]), 32'h13FC0);
      d0 = done_cnt;
      pulse_update();
      s = cyc;
      wait_words("t1", 18, 40);
      check("t1_latency", first_xfer_cyc - s, 1);
      check("t1_no_bubble", last_xfer_cyc - first_xfer_cyc, 17);
      check_frame("t1");
      repeat (2) step();
      check("t1_done_cnt", done_cnt - d0, 1);
      check("t1_idle_busy", 32'(busy), 0);

      // Random backpressure
      randomize_inputs();
      model_frame(regs, brightness, logic'(show));
      d0 = done_cnt;
      rand_ready = 1'b1;
      pulse_update();
      wait_words("t2", 18, 300);
      rand_ready = 1'b0;
      check_frame("t2");
      repeat (4) step();
      check("t2_done_cnt", done_cnt - d0, 1);
      check("t2_no_extra", got_q.size(), 0);

      // Updates during the frame coalesce into one back-to-back frame
      randomize_inputs();
      model_frame(regs, brightness, logic'(show));
      d0 = done_cnt;
      pulse_update();
      wait_words("t3a", 7, 40);
      watch_busy = 1'b1;
      pulse_update();
      step();
      pulse_update();
      repeat (3) step();
      pulse_update();
      wait_words("t3", 36, 80);
      watch_busy = 1'b0;
      check_frame("t3a");
      check_frame("t3b");
      repeat (10) step();
      check("t3_done_cnt", done_cnt - d0, 2);
      check("t3_no_third", got_q.size(), 0);
      check("t3_busy_held", busy_low, 0);

      // Image changes mid-frame: current frame keeps old snapshot
      randomize_inputs();
      regs_a = regs; bright_a = brightness; show_a = show;
      pulse_update();
      wait_words("t4a", 5, 40);
      randomize_inputs();
      pulse_update();
      wait_words("t4", 36, 80);
      model_frame(regs_a, bright_a, logic'(show_a));
      check_frame("t4a");
      model_frame(regs, brightness, logic'(show));
      check_frame("t4b");
      repeat (3) step();

      // Reset during word 9
      randomize_inputs();
      model_frame(regs, brightness, logic'(show));
      pulse_update();
      wait_words("t5a", 9, 40);
      d0 = done_cnt;
      rst_n = 1'b0;
      #1;
      check("t5_rst_valid", 32'(cmd_valid), 0);
      check("t5_rst_busy", 32'(busy), 0);
      check("t5_rst_cmd", 32'(cmd), 0);
      got_q.delete();
      prev_stall = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      repeat (10) step();
      check("t5_no_done", done_cnt - d0, 0);
      check("t5_idle_words", got_q.size(), 0);
      check("t5_idle_busy", 32'(busy), 0);
      pulse_update();
      wait_words("t5", 18, 40);
      check_frame("t5");
      repeat (3) step();
      check("t5_done_cnt", done_cnt - d0, 1);

      // Auto-refresh period, including update colliding with refresh expiry
      randomize_inputs();
      model_frame(regs, brightness, logic'(show));
      d = r_done_cnt;
      b = 0;
      while (r_done_cnt == d && b < 100) begin step(); b++; end
      check("r_first_done", 32'(r_done_cnt != d), 1);
      for (int it = 0; it < 4; it++) begin
         d  = r_done_cyc;
         d0 = r_done_cnt;
         r_got_q.delete();
         b = 0;
         while (r_done_cnt == d0 && b < 100) begin
            step();
            b++;
            update_r = (it == 1 && cyc == d + 19);
         end
         update_r = 1'b0;
         check($sformatf("r_gap%0d", it), r_rise_cyc - d, 21);
         check($sformatf("r_len%0d", it), r_got_q.size(), 18);
         for (int i = 0; i < 18; i++) begin
            if (i >= r_got_q.size()) break;
            check($sformatf("r%0d_w%0d", it, i), 32'(r_got_q[i]), 32'(exp_w[i]));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tm1638_frame_sequencer.md
TM1638_FRAME_SEQUENCER -- requirements
Module: tm1638_frame_sequencer

Interface
REQ-001 Parameter REFRESH_CYCLES, default 1_000_000, sets the clk cycles from end of one frame to auto-start of the next; 0 disables auto-refresh.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 update  input  1  single-cycle request to send a new frame.
REQ-005 regs  input  16x8  display register image, index 0..15 = register_t encoding.
REQ-006 brightness  input  3  brightness_t for the control command.
REQ-007 show  input  1  show_t for the control command.
REQ-008 cmd  output  18  command word in the shared 18-bit command format.
REQ-009 cmd_valid  output  1  cmd is presented.
REQ-010 cmd_ready  input  1  serial driver accepts cmd.
REQ-011 busy  output  1  frame in progress.
REQ-012 frame_done  output  1  single-cycle pulse after the last command of a frame transfers.

Function
REQ-013 States: IDLE, DATA_CMD, ADDR, CTRL, DONE; one frame = DATA_CMD, ADDR x16, CTRL = 18 commands.
REQ-014 Frame start: update high in IDLE, or refresh counter reaching REFRESH_CYCLES-1 in IDLE, moves to DATA_CMD next cycle.
REQ-015 At frame start, regs, brightness and show are snapshotted; the whole frame uses the snapshot.
REQ-016 DATA_CMD presents make_write_data_command(ADDR_MODE_FIXED, DATA_MODE_NORMAL) = 18'h00044.
REQ-017 ADDR presents make_addr_command_and_data(grid=idx[3:1], data=regs[idx], segment=idx[0]); idx runs 0..15 in order.
REQ-018 CTRL presents make_control_command(show, brightness).
REQ-019 cmd_valid is high in DATA_CMD, ADDR and CTRL, and low in IDLE and DONE.
REQ-020 First cmd_valid occurs exactly one cycle after the start trigger.
REQ-021 A transfer is cmd_valid && cmd_ready on a rising edge.
REQ-022 cmd holds stable while cmd_valid && !cmd_ready.
REQ-023 After each transfer, the next command is presented the following cycle with cmd_valid kept high, giving no bubble and a one-per-cycle maximum rate.
REQ-024 Transfer of CTRL enters DONE, which asserts frame_done for one cycle, then returns to IDLE.
REQ-025 busy is high in every state except IDLE.
REQ-026 Refresh counter is cleared on entry to IDLE and counts only in IDLE.
REQ-027 update while busy sets a pending flag, and multiple updates coalesce to one.
REQ-028 In DONE, a set pending flag (or update in the same cycle) clears the flag and goes to DATA_CMD instead of IDLE; frame_done still pulses.
REQ-029 update in the same cycle as refresh expiry starts one frame only.
REQ-030 cmd_ready while cmd_valid is low has no effect.
REQ-031 idx wraps only via state exit; it is never reused past 15.

Reset
REQ-032 rst_n low asynchronously forces IDLE, cmd_valid=0, cmd=0, busy=0, frame_done=0, idx=0, pending=0, refresh counter=0, and snapshot=0.
REQ-033 A reset mid-frame abandons the frame and does not pulse frame_done.
REQ-034 After rst_n rises, the first frame starts only on update or refresh expiry.

Structure
REQ-035 Command builders, enums, register_t, brightness_t and data_t come from the shared tm1638_types package; the state enum lives in the same package as tm1638_seq_state_t.
REQ-036 The refresh counter is a sub-module, tm1638_refresh_timer (parameter width derived by $clog2, ports clear, tick).
REQ-037 No other sub-modules.

Verification
REQ-038 update pulse with cmd_ready=1, regs[0]=8'h3F, regs[5]=8'h06, others 0, brightness=7, show=1 -> 18 consecutive valid cycles: 18'h00044, 18'h13FC0, 4 x reg1..4, 18'h106C5, ..., last 18'h0008F; frame_done one cycle later.
REQ-039 cmd_ready toggled 1/0 randomly -> same 18-word sequence, cmd stable during stalls, no word dropped or duplicated.
REQ-040 update during word 7 plus two more updates -> exactly one extra frame follows back-to-back; busy stays high across it.
REQ-041 regs changed mid-frame -> current frame carries the old values; the next frame carries the new values.
REQ-042 REFRESH_CYCLES=20, no update -> frame starts 20 cycles after IDLE entry, repeatedly.
REQ-043 rst_n low during word 9 -> cmd_valid and busy drop immediately, no frame_done, idle until next trigger.
